mod_mult_pipe: RTL and testbench
================================

// Module: mod_mult_pipe
// PURPOSE
//  Pipelined Barrett modular multiplier: result = (a*b) mod Q, one product per clock.
//  Valid/ready streaming with a sideband tag. Replaces the combinational multiply/% path.
//  Sits inside the NTT butterfly datapath (twiddle x coefficient) and the pointwise-multiply engine.
// PARAMETERS
//  WIDTH  32    operand/result bus width; Q < 2**WIDTH required
//  Q      3329  odd modulus, 3 <= Q < 2**30 (elaboration $error otherwise)
//  TAG_W  8     sideband tag width (e.g. coefficient index), carried unchanged
//  (local) QW=$clog2(Q), K=2*QW, MU=floor(2**K/Q), computed as 64-bit localparams
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      block accepts operands this cycle
//  in_a       in   WIDTH  operand a, must be < Q
//  in_b       in   WIDTH  operand b, must be < Q
//  in_tag     in   TAG_W  sideband, returned with the result
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_result out  WIDTH  (a*b) mod Q, zero-extended from QW bits
//  out_tag    out  TAG_W  tag of the returned result
//  busy       out  1      OR of all stage valid bits
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids=0, data regs=0.
//    out_valid=0, out_result=0, out_tag=0, busy=0; in_ready=1 once reset is released.
//  - Transfer rules: an input transfer is in_valid&in_ready; an output transfer is out_valid&out_ready.
//  - Pipeline enable: adv = out_ready | ~out_valid; in_ready = adv (combinational).
//    When adv=0 all stages hold; no bubble collapse.
//  - 4 stages, latency 4 cycles when unstalled (input at edge n -> out_valid after edge n+4).
//  - Throughput 1/cycle; valid bits and tags shift with the data.
//    - S1: x = a[QW-1:0]*b[QW-1:0], 2*QW bits.
//    - S2: t = (x*MU) >> K, registered with x.
//    - S3: r = x - t*Q, kept QW+2 bits, non-negative by construction.
//    - S4: r -= Q if r>=Q, applied up to twice (r < 3Q bound); result in [0,Q).
//  - Bubbles (in_valid=0 while adv=1) shift as invalid stages; data regs need not clear.
//  - out_result/out_tag stable while out_valid & ~out_ready (AXI-style hold).
//  - Operands >= Q: handshake still correct, result undefined; SVA flags in_valid & (in_a>=Q | in_b>=Q).
//  - Simultaneous out transfer + in transfer while full: legal, no loss, no duplication.
//  - Reset mid-stream: in-flight results discarded, nothing emitted after release until new inputs pass 4 stages.
//  - No combinational path in_valid -> out_valid; only out_ready -> in_ready is combinational.
// TESTING
//  - Q=3329: a=3328, b=3328 -> out_result=1 exactly 4 cycles after accept; a=17, b=1729 -> 2761.
//  - a=0, b=1234, tag=0x5A -> out_result=0, out_tag=0x5A; a=1, b=3328 -> 3328 (no over-subtract).
//  - Stream 16 back-to-back pairs, out_ready=1 -> 16 results in order on consecutive cycles, tags 0..15.
//  - Fill pipe, drop out_ready for 3 cycles -> in_ready=0, out_* held constant, busy=1.
//    Then resume -> no loss/duplication.
//  - Assert rst_n=0 with 3 items in flight -> out_valid=0 and busy=0 immediately.
//    After release: no stale output.
//  - Random 10k pairs, random ready/valid gaps, Q in {3329, 8380417, 12289} -> match (a*b)%Q model.

Source files
------------

// File: rtl/mod_mult_pipe.sv
// Pipelined Barrett modular multiplier: out_result = (in_a * in_b) mod Q.
// Four register stages, one product per clock, valid/ready streaming with a sideband tag.
// The whole pipe advances together; a stalled output freezes every stage.
module mod_mult_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned Q     = 3329,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned QW  = $clog2(Q);
    localparam int unsigned K   = 2 * QW;
    localparam int unsigned XW  = 2 * QW;      // full product a*b
    localparam int unsigned PW  = 3 * QW + 1;  // x*MU, MU fits in QW+1 bits
    localparam int unsigned RW  = QW + 2;      // remainder before correction, < 3Q
    localparam logic [63:0] Q64 = 64'(Q);
    localparam logic [63:0] MU  = (64'd1 << K) / Q64;

    if (Q < 3 || Q >= (1 << 30) || (Q % 2) == 0 || (Q64 >> WIDTH) != 64'd0) begin : g_bad_q
        $error("mod_mult_pipe: Q must be odd, 3 <= Q < 2**30 and Q < 2**WIDTH");
    end

    logic             v1_q, v2_q, v3_q, v4_q;
    logic             v1_d, v2_d, v3_d, v4_d;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q, tag4_q;
    logic [TAG_W-1:0] tag1_d, tag2_d, tag3_d, tag4_d;
    logic [XW-1:0]    x1_q, x2_q, x1_d, x2_d;
    logic [QW-1:0]    t2_q, t2_d;
    logic [RW-1:0]    r3_q, r3_d;
    logic [QW-1:0]    res4_q, res4_d;

    logic             adv;
    logic [PW-1:0]    mu_prod;
    logic [RW-1:0]    tq;
    logic [RW-1:0]    red1, red2;

    // Global enable: the pipe moves whenever the output slot is free or being drained.
    always_comb begin
        adv = out_ready | ~v4_q;
    end

    // Datapath arithmetic for each stage boundary.
    always_comb begin
        mu_prod = PW'(x1_q) * PW'(MU);
        // Modular arithmetic in RW bits is exact because x - t*Q is known to be < 3Q.
        tq      = RW'(t2_q) * RW'(Q);
        red1    = (r3_q >= RW'(Q)) ? (r3_q - RW'(Q)) : r3_q;
        red2    = (red1 >= RW'(Q)) ? (red1 - RW'(Q)) : red1;
    end

    // Next-state: every stage loads from its predecessor on adv, otherwise holds.
    always_comb begin
        v1_d   = v1_q;
        v2_d   = v2_q;
        v3_d   = v3_q;
        v4_d   = v4_q;
        tag1_d = tag1_q;
        tag2_d = tag2_q;
        tag3_d = tag3_q;
        tag4_d = tag4_q;
        x1_d   = x1_q;
        x2_d   = x2_q;
        t2_d   = t2_q;
        r3_d   = r3_q;
        res4_d = res4_q;
        if (adv) begin
            v1_d   = in_valid;
            tag1_d = in_tag;
            x1_d   = XW'(in_a[QW-1:0]) * XW'(in_b[QW-1:0]);
            v2_d   = v1_q;
            tag2_d = tag1_q;
            x2_d   = x1_q;
            t2_d   = mu_prod[K +: QW];
            v3_d   = v2_q;
            tag3_d = tag2_q;
            r3_d   = x2_q[RW-1:0] - tq;
            v4_d   = v3_q;
            tag4_d = tag3_q;
            res4_d = red2[QW-1:0];
        end
    end

    // Pipeline registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            v4_q   <= 1'b0;
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
            tag4_q <= '0;
            x1_q   <= '0;
            x2_q   <= '0;
            t2_q   <= '0;
            r3_q   <= '0;
            res4_q <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            v4_q   <= v4_d;
            tag1_q <= tag1_d;
            tag2_q <= tag2_d;
            tag3_q <= tag3_d;
            tag4_q <= tag4_d;
            x1_q   <= x1_d;
            x2_q   <= x2_d;
            t2_q   <= t2_d;
            r3_q   <= r3_d;
            res4_q <= res4_d;
        end
    end

    // Outputs come straight from the last stage, so they hold while stalled.
    always_comb begin
        in_ready   = adv;
        out_valid  = v4_q;
        out_result = WIDTH'(res4_q);
        out_tag    = tag4_q;
        busy       = v1_q | v2_q | v3_q | v4_q;
    end

    // Operands must already be reduced mod Q.
    operand_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        in_valid |-> (in_a < WIDTH'(Q) && in_b < WIDTH'(Q)));

endmodule

// File: tb/tb_mod_mult_pipe.sv
// Self-checking bench for mod_mult_pipe: directed vectors, streaming, stall, reset,
// and randomized traffic on three moduli against a plain (a*b)%Q model.
module tb_mod_mult_pipe;

    localparam int unsigned NRND = 3400;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] in_a, in_b, out_result;
    logic [7:0]  in_tag, out_tag;
    logic        rand_go;
    int          done_cnt;
    int          total, bad;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  tag;
        logic [31:0] exp;
    } vec_t;

    mod_mult_pipe #(.WIDTH(32), .Q(3329), .TAG_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mm(input logic [31:0] a, input logic [31:0] b,
                                       input longint unsigned q);
        longint unsigned p;
        p = (longint'(a) * longint'(b)) % q;
        return p[31:0];
    endfunction

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] tg);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_tag   = tg;
    endtask

    // Randomized traffic on three moduli, each with its own queue-based scoreboard.
    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int unsigned QG = (g == 0) ? 3329 : ((g == 1) ? 8380417 : 12289);
        logic        iv, ir, ov, ordy, bsy;
        logic [31:0] ia, ib, ores;
        logic [7:0]  it, ot;

        mod_mult_pipe #(.WIDTH(32), .Q(QG), .TAG_W(8)) u_rnd (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_a      (ia),
            .in_b      (ib),
            .in_tag    (it),
            .out_valid (ov),
            .out_ready (ordy),
            .out_result(ores),
            .out_tag   (ot),
            .busy      (bsy)
        );

        initial begin
            logic [39:0] expq[$];
            logic [39:0] held;
            logic        fire, hold;
            int          sent, got, cyc;
            iv = 1'b0; ordy = 1'b0; ia = '0; ib = '0; it = '0;
            sent = 0; got = 0; cyc = 0; hold = 1'b0; held = '0;
            wait (rand_go);
            while (got < NRND && cyc < 40000) begin
                @(negedge clk);
                if (hold) chk("rnd_hold", {ov, ot, ores}, {1'b1, held});
                if (ov && ordy) begin
                    if (expq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rnd_extra: got tag %0d result %0d, expected no output",
                                 ot, ores);
                    end else begin
                        chk("rnd_result", {ot, ores}, expq.pop_front());
                    end
                    got++;
                end
                hold = ov && !ordy;
                held = {ot, ores};
                fire = iv && ir;
                if (fire) begin
                    expq.push_back({it, mm(ia, ib, QG)});
                    sent++;
                end
                @(posedge clk);
                #1;
                cyc++;
                if (fire || !iv) begin
                    iv = (sent < int'(NRND)) && ($urandom_range(3) != 0);
                    ia = $urandom_range(QG - 1);
                    ib = $urandom_range(QG - 1);
                    it = 8'(sent);
                end
                ordy = ($urandom_range(3) != 0);
            end
            if (got < int'(NRND)) chk("rnd_timeout", 64'(got), 64'(NRND));
            iv = 1'b0;
            done_cnt++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[8];
        logic [31:0] sa[16], sb[16], ea[16];
        int          idx, recv, quiet;

        vt[0] = '{a: 32'd3328, b: 32'd3328, tag: 8'h01, exp: 32'd1};
        vt[1] = '{a: 32'd17,   b: 32'd1729, tag: 8'h02, exp: 32'd2761};
        vt[2] = '{a: 32'd0,    b: 32'd1234, tag: 8'h5A, exp: 32'd0};
        vt[3] = '{a: 32'd1,    b: 32'd3328, tag: 8'h03, exp: 32'd3328};
        vt[4] = '{a: 32'd3328, b: 32'd1,    tag: 8'h04, exp: 32'd3328};
        vt[5] = '{a: 32'd2,    b: 32'd1665, tag: 8'h05, exp: 32'd1};
        vt[6] = '{a: 32'd1664, b: 32'd2,    tag: 8'h06, exp: 32'd3328};
        vt[7] = '{a: 32'd3000, b: 32'd3000, tag: 8'hA7, exp: 32'd1713};

        total = 0; bad = 0; done_cnt = 0; rand_go = 1'b0;
        rst_n = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(out_result), 64'd0);
        chk("reset_tag", 64'(out_tag), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors: output appears after the 4th edge following presentation.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vt[i].a, vt[i].b, vt[i].tag);
            chk("vec_in_ready", 64'(in_ready), 64'd1);
            for (int e = 1; e <= 4; e++) begin
                @(posedge clk);
                #1;
                if (e == 1) drive(1'b0, 32'd0, 32'd0, 8'd0);
                if (e < 4) chk("vec_latency", 64'(out_valid), 64'd0);
            end
            chk("vec_out_valid", 64'(out_valid), 64'd1);
            chk("vec_result", 64'(out_result), 64'(vt[i].exp));
            chk("vec_tag", 64'(out_tag), 64'(vt[i].tag));
            @(posedge clk);
            #1;
        end

        // 16 back-to-back pairs with out_ready held high.
        for (int k = 0; k < 16; k++) begin
            sa[k] = $urandom_range(3328);
            sb[k] = $urandom_range(3328);
            ea[k] = mm(sa[k], sb[k], 3329);
        end
        for (int c = 0; c < 24; c++) begin
            if (c < 16) drive(1'b1, sa[c], sb[c], 8'(c));
            else drive(1'b0, 32'd0, 32'd0, 8'd0);
            @(negedge clk);
            if (c >= 4 && c < 20) begin
                chk("stream_valid", 64'(out_valid), 64'd1);
                chk("stream_tag", 64'(out_tag), 64'(c - 4));
                chk("stream_result", 64'(out_result), 64'(ea[c - 4]));
            end else begin
                chk("stream_gap", 64'(out_valid), 64'd0);
            end
            @(posedge clk);
            #1;
        end

        // Fill the pipe with out_ready low, stall three cycles, then drain.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sa[k] = $urandom_range(3328);
            sb[k] = $urandom_range(3328);
            ea[k] = mm(sa[k], sb[k], 3329);
        end
        idx = 0; recv = 0;
        for (int c = 0; c < 40 && recv < 5; c++) begin
            out_ready = (c >= 7);
            if (idx < 5) drive(1'b1, sa[idx], sb[idx], 8'(8'h20 + idx));
            else drive(1'b0, 32'd0, 32'd0, 8'd0);
            @(negedge clk);
            if (c >= 4 && c <= 6) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_busy", 64'(busy), 64'd1);
                chk("stall_tag", 64'(out_tag), 64'h20);
                chk("stall_result", 64'(out_result), 64'(ea[0]));
            end
            if (out_valid && out_ready) begin
                chk("drain_tag", 64'(out_tag), 64'(8'h20 + recv));
                chk("drain_result", 64'(out_result), 64'(ea[recv]));
                recv++;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
        end
        drive(1'b0, 32'd0, 32'd0, 8'd0);
        chk("drain_count", 64'(recv), 64'd5);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_empty_valid", 64'(out_valid), 64'd0);
        chk("drain_empty_busy", 64'(busy), 64'd0);

        // Reset with three items in flight.
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'(100 + k), 32'd7, 8'(8'h40 + k));
            @(posedge clk);
            #1;
        end
        drive(1'b0, 32'd0, 32'd0, 8'd0);
        chk("preflush_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid || busy) quiet++;
        end
        chk("post_reset_stale", 64'(quiet), 64'd0);
        @(posedge clk);
        #1;
        drive(1'b1, 32'd17, 32'd1729, 8'h77);
        @(posedge clk);
        #1;
        drive(1'b0, 32'd0, 32'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_result", {out_valid, out_tag, out_result}, {1'b1, 8'h77, 32'd2761});

        // Randomized phase on all three moduli.
        rand_go = 1'b1;
        for (int c = 0; c < 60000 && done_cnt < 3; c++) @(posedge clk);
        chk("rnd_all_done", 64'(done_cnt), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
